// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters and times each frame.
// Define TX_ARB_FIXED_PRIO_EN to select fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int COUNTS_PER_BIT = 434,
  parameter int GAP_CYCLES     = 2,
  parameter int IDX_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TMR_WIDTH      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ*2-1:0]           req_parity,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic                           tx_send,
  output logic [1:0]                     tx_parity_type,
  output logic                           busy,
  output logic [IDX_WIDTH-1:0]           grant_idx
);

  localparam int FRAME_NP = (2 + DATA_BITS) * COUNTS_PER_BIT + 2;
  localparam int FRAME_P  = (3 + DATA_BITS) * COUNTS_PER_BIT + 2;
  localparam logic [TMR_WIDTH-1:0] FRAME_NP_M1 = TMR_WIDTH'(FRAME_NP - 1);
  localparam logic [TMR_WIDTH-1:0] FRAME_P_M1  = TMR_WIDTH'(FRAME_P - 1);
  localparam logic [TMR_WIDTH-1:0] GAP_M1      = TMR_WIDTH'(GAP_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_FRAME,
    S_GAP
  } state_t;

  state_t                 state;
  logic [TMR_WIDTH-1:0]   timer;
  logic [IDX_WIDTH-1:0]   pick_idx;
  logic [DATA_BITS-1:0]   pick_data;
  logic [1:0]             pick_par;

  // Mode 3 is undefined on the transmitter side, so it is sent as "no parity".
  function automatic logic [1:0] map_parity(input logic [1:0] p);
    return (p == 2'd3) ? 2'd0 : p;
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_WIDTH-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (idx == IDX_WIDTH'(i)) v[i] = 1'b1;
    return v;
  endfunction

`ifdef TX_ARB_FIXED_PRIO_EN
  function automatic logic [IDX_WIDTH-1:0] prio_pick(input logic [NUM_REQ-1:0] r);
    logic [IDX_WIDTH-1:0] sel;
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (r[i]) sel = IDX_WIDTH'(i);
    return sel;
  endfunction
`else
  logic [IDX_WIDTH-1:0] ptr;

  function automatic logic [IDX_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                   input logic [IDX_WIDTH-1:0] p);
    logic [IDX_WIDTH-1:0] sel;
    logic                 found;
    int                   idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(p) + i) % NUM_REQ;
      if (!found && r[idx]) begin
        sel   = IDX_WIDTH'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction
`endif

  always_comb begin
`ifdef TX_ARB_FIXED_PRIO_EN
    pick_idx = prio_pick(req);
`else
    pick_idx = rr_pick(req, ptr);
`endif
    pick_data = '0;
    pick_par  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_WIDTH'(i)) begin
        pick_data = req_data[i*DATA_BITS +: DATA_BITS];
        pick_par  = req_parity[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      timer          <= '0;
      ack            <= '0;
      tx_data        <= '0;
      tx_send        <= 1'b0;
      tx_parity_type <= 2'd0;
      busy           <= 1'b0;
      grant_idx      <= '0;
`ifndef TX_ARB_FIXED_PRIO_EN
      ptr            <= '0;
`endif
    end else begin
      tx_send <= 1'b0;
      ack     <= '0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant_idx      <= pick_idx;
            tx_data        <= pick_data;
            tx_parity_type <= map_parity(pick_par);
            busy           <= 1'b1;
            state          <= S_LOAD;
          end else begin
            busy <= 1'b0;
          end
        end
        // Strobe is registered here so it is high during the S_SEND cycle.
        S_LOAD: begin
          tx_send <= 1'b1;
          state   <= S_SEND;
        end
        S_SEND: begin
          timer <= (tx_parity_type == 2'd1 || tx_parity_type == 2'd2) ? FRAME_P_M1 : FRAME_NP_M1;
          state <= S_FRAME;
        end
        // Ack is launched one cycle early so it coincides with the timer==0 cycle.
        S_FRAME: begin
          if (timer == TMR_WIDTH'(1)) ack <= one_hot(grant_idx);
          if (timer == '0) begin
`ifndef TX_ARB_FIXED_PRIO_EN
            ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_WIDTH'(1);
`endif
            timer <= GAP_M1;
            state <= S_GAP;
          end else begin
            timer <= timer - TMR_WIDTH'(1);
          end
        end
        S_GAP: begin
          if (timer == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            timer <= timer - TMR_WIDTH'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: latency, frame timing, parity mapping, arbitration order, reset.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_BITS = 8;
  localparam int CPB       = 434;
  localparam int GAP       = 2;
  localparam int F_NP      = 10 * 434 + 2;
  localparam int F_P       = 11 * 434 + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [7:0]  req_parity;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic [1:0]  tx_parity_type;
  logic        busy;
  logic [1:0]  grant_idx;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS), .COUNTS_PER_BIT(CPB),
    .GAP_CYCLES(GAP), .IDX_WIDTH(2), .TMR_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_parity(req_parity),
    .ack(ack), .tx_data(tx_data), .tx_send(tx_send), .tx_parity_type(tx_parity_type),
    .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Runs one frame from the current req setting; lat is tx_send cycle minus call cycle.
  task automatic frame(input string tag, input logic [7:0] exp_data, input logic [1:0] exp_par,
                       input logic [1:0] exp_idx, input int exp_len, input int exp_lat,
                       input logic churn, output int c_ack);
    int       c0, c_s, changes;
    logic [7:0] d0;
    logic [1:0] p0;
    c0 = cyc; c_s = -1; c_ack = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (tx_send) begin c_s = cyc; break; end
    end
    if (c_s < 0) begin
      chk({tag, "_send_timeout"}, 32'(tx_send), 1);
      return;
    end
    chk({tag, "_latency"}, c_s - c0, exp_lat);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'(exp_data));
    chk({tag, "_parity"}, 32'(tx_parity_type), 32'(exp_par));
    chk({tag, "_grant_idx"}, 32'(grant_idx), 32'(exp_idx));
    chk({tag, "_busy"}, 32'(busy), 1);
    d0 = tx_data; p0 = tx_parity_type; changes = 0;
    tick();
    chk({tag, "_send_1cyc"}, 32'(tx_send), 0);
    for (int k = 0; k < 6000; k++) begin
      if (churn) begin
        req_data[15:8]   = req_data[15:8] + 8'h1B;
        req_parity[3:2]  = req_parity[3:2] + 2'd1;
      end
      if (ack != 4'd0) begin c_ack = cyc; break; end
      if (tx_data !== d0 || tx_parity_type !== p0) changes++;
      tick();
    end
    if (c_ack < 0) begin
      chk({tag, "_ack_timeout"}, 32'(ack), 32'(4'd1 << exp_idx));
      return;
    end
    chk({tag, "_ack_vec"}, 32'(ack), 32'(4'd1 << exp_idx));
    chk({tag, "_frame_len"}, c_ack - c_s, exp_len);
    chk({tag, "_held_changes"}, changes, 0);
  endtask

  initial begin
    int ca, pulses;
    rst = 1'b0; req = '0; req_data = '0; req_parity = '0;
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_outs", {20'd0, tx_data, tx_send, tx_parity_type, busy}, 0);
    chk("rst_grant", 32'(grant_idx), 0);
    idle(2);
    rst = 1'b1;
    idle(3);

    // Single request, no parity.
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    frame("single", 8'hA5, 2'd0, 2'd0, F_NP, 2, 1'b0, ca);
    req = '0;
    tick();
    chk("single_ack_1cyc", 32'(ack), 0);
    idle(6);
    chk("single_busy_clear", 32'(busy), 0);

    // Odd parity lengthens the frame by one bit.
    req_data[23:16] = 8'h3C; req_parity[5:4] = 2'd1;
    req = 4'b0100;
    frame("parity", 8'h3C, 2'd1, 2'd2, F_P, 2, 1'b0, ca);
    req = '0;
    idle(6);

    // Mode 3 behaves as no parity; granted requester's inputs churn mid-frame.
    req_data[15:8] = 8'h77; req_parity = 8'b00_00_11_00;
    req = 4'b0010;
    frame("par3", 8'h77, 2'd0, 2'd1, F_NP, 2, 1'b1, ca);
    chk("par3_tx_data_end", 32'(tx_data), 32'h77);
    req = '0;
    req_parity = '0;
    idle(6);

    // Reset in the middle of a frame.
    req_data[7:0] = 8'h5A;
    req = 4'b0001;
    for (int k = 0; k < 20 && !tx_send; k++) tick();
    idle(100);
    chk("mid_busy_before", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_outs", {20'd0, tx_data, tx_send, tx_parity_type, busy}, 0);
    chk("mid_rst_ack_grant", {ack, 2'b00, grant_idx}, 0);
    req = '0;
    idle(2);
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5000; k++) begin
      tick();
      if (ack != 4'd0 || busy) pulses++;
    end
    chk("mid_no_ack_after", pulses, 0);

    // Round-robin with every requester asserting.
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req = 4'b1111;
    frame("rr0", 8'hA0, 2'd0, 2'd0, F_NP, 2, 1'b0, ca);
    frame("rr1", 8'hB1, 2'd0, 2'd1, F_NP, GAP + 3, 1'b0, ca);
    frame("rr2", 8'hC2, 2'd0, 2'd2, F_NP, GAP + 3, 1'b0, ca);
    frame("rr3", 8'hD3, 2'd0, 2'd3, F_NP, GAP + 3, 1'b0, ca);
    frame("rr4", 8'hA0, 2'd0, 2'd0, F_NP, GAP + 3, 1'b0, ca);
    req = '0;
    idle(6);

    // Two held requesters: round-robin alternates, fixed priority repeats the low one.
    req = 4'b1010;
    frame("pair_a", 8'hB1, 2'd0, 2'd1, F_NP, 2, 1'b0, ca);
`ifdef TX_ARB_FIXED_PRIO_EN
    frame("pair_b", 8'hB1, 2'd0, 2'd1, F_NP, GAP + 3, 1'b0, ca);
`else
    frame("pair_b", 8'hD3, 2'd0, 2'd3, F_NP, GAP + 3, 1'b0, ca);
`endif
    req = '0;
    idle(6);
    chk("end_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (start/data/optional parity/stop framing, single-cycle `send_data` strobe, live-sampled `data`) among NUM_REQ requesters.
- Arbitrates round-robin, latches the winner's byte and parity mode, and strobes the transmitter.
- Holds data and parity stable for the whole frame, times the frame internally (the transmitter has no busy output), then acks the requester.
- Sits between the application/command logic and the transmitter in the UART top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BITS, 8, bits per character; must match the transmitter.
- COUNTS_PER_BIT, 434, clocks per bit; must match the transmitter.
- GAP_CYCLES, 2, idle-line clocks enforced after each frame before the next grant (>=1).
- IDX_WIDTH, $clog2(NUM_REQ) (min 1), grant index width.
- TMR_WIDTH, 32, frame timer width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level request per requester; held until ack
- req_data  in  NUM_REQ*DATA_BITS  character per requester; slice i = bits [i*DATA_BITS +: DATA_BITS]
- req_parity  in  NUM_REQ*2  parity mode per requester; slice i = [i*2 +: 2]; 0 none, 1 odd, 2 even, 3 treated as none
- ack  out  NUM_REQ  one-cycle pulse to the granted requester at frame end
- tx_data  out  DATA_BITS  to transmitter `data`
- tx_send  out  1  to transmitter `send_data`; one-cycle pulse
- tx_parity_type  out  2  to transmitter `parity_type`
- busy  out  1  high from grant until the gap expires
- grant_idx  out  IDX_WIDTH  index of the current or last granted requester

Behaviour:
- Reset (rst=0, async) values:
  - ack=0, tx_data=0, tx_send=0, tx_parity_type=0, busy=0, grant_idx=0.
  - Round-robin pointer = 0; state = S_IDLE; timer = 0.
- States: S_IDLE, S_LOAD, S_SEND, S_FRAME, S_GAP.
- S_IDLE:
  - If req!=0, pick the first set bit searching from pointer upward with wrap.
  - Register grant_idx, tx_data and tx_parity_type (3 mapped to 0); set busy=1; go to S_LOAD.
  - Otherwise stay; busy=0.
- S_LOAD: one cycle so tx_data and tx_parity_type settle before the strobe; go to S_SEND.
- S_SEND:
  - tx_send=1 for exactly this cycle.
  - Load timer = FRAME_CLKS-1; go to S_FRAME.
- FRAME_CLKS = (2 + DATA_BITS + P) * COUNTS_PER_BIT + 2.
  - P = 1 if the latched parity is 1 or 2, else 0.
  - The +2 covers the transmitter's IDLE->START cycle and its STOP->IDLE return.
- S_FRAME:
  - Decrement timer. tx_data and tx_parity_type are held constant; requester inputs are ignored.
  - At timer==0: ack[grant_idx]=1 for one cycle; pointer = grant_idx+1 (wrap at NUM_REQ); timer = GAP_CYCLES-1; go to S_GAP.
- S_GAP:
  - Decrement timer. At 0: busy=0; go to S_IDLE.
  - The next grant is evaluated no earlier than the S_IDLE cycle.
- Latency: request seen in S_IDLE -> tx_send two cycles later. Back-to-back frames are separated by at least GAP_CYCLES+1 idle clocks.
- Requester behaviour:
  - A requester may drop req early. The frame still completes and ack still pulses; nothing aborts a started frame.
  - Any requester may change req_data or req_parity while not granted without effect.
  - The granted requester's changes after S_IDLE are ignored.
- Simultaneous events:
  - A new req arriving in the ack cycle is queued; it is served after the gap.
  - A granted requester still asserting req in S_IDLE loses to others, because the pointer has already moved past it.
- Reset mid-frame:
  - All outputs return to reset values immediately.
  - The transmitter is reset by the same top-level reset, inverted to its active-high rst, so no partial frame continues.
- The ack vector is one-hot or zero at all times.

Optional Feature:
- Macro TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest index wins; the pointer register is removed. Ack, timing and gap rules are unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Reset → outputs: assert rst=0 mid-S_FRAME → all outputs 0, busy=0, and no ack pulse after release.
- Single request, no parity: req=4'b0001, req_data[7:0]=8'hA5, parity 0 →
  - tx_data=8'hA5 and tx_send pulses 2 clocks after the request.
  - ack[0] pulses 10*434+2 clocks after tx_send.
  - The decoded serial line carries 0xA5.
- Parity timing: req=4'b0100, data 8'h3C, parity 1 →
  - tx_parity_type=1 and grant_idx=2.
  - ack[2] pulses 11*434+2 clocks after tx_send.
  - The parity bit on the line is 1.
- Round-robin fairness: req=4'b1111 held, each requester re-asserting after its ack → grant order 0,1,2,3,0; each tx_send is at least GAP_CYCLES+1 clocks after the previous ack.
- Parity mode 3 and input churn:
  - req=4'b0010 with parity 3 → tx_parity_type=0 and frame timed as no parity.
  - Toggle req_data[15:8] during S_FRAME → tx_data stays at the value latched at grant.
- Fixed priority build (TX_ARB_FIXED_PRIO_EN): req=4'b1010 held → requester 1 granted every time and requester 3 never granted.
